// File: rtl/bmem_pkg.sv
// Shared types and constants for the banked-memory arbiter and its line collectors.
package bmem_pkg;

  localparam int ADDR_W = 32;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = 2;
  localparam int OFFS_W = 5;  // byte offset bits inside a 32-byte line

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    WR_BEAT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // One outstanding line read: owner-side bookkeeping plus the assembly buffer.
  typedef struct packed {
    logic              pending;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  beat_cnt;
    logic [LINE_W-1:0] line_buf;
  } line_tracker_t;

  // Clear the byte offset so every command and tag compare uses the line address.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/bmem_line_collector.sv
// Tracks one outstanding line read, gathers its four returning beats by tag
// match and emits a one-cycle completion pulse with the assembled line.
module bmem_line_collector
  import bmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              rvalid_i,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [BEAT_W-1:0] rdata_i,
  output logic              pending_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              resp_valid_o,
  output logic [LINE_W-1:0] resp_rdata_o
);

  line_tracker_t trk_q, trk_d;
  logic          resp_valid_q, resp_valid_d;
  logic          hit;

  // A beat belongs to this tracker only while a read is outstanding for its line.
  assign hit = rvalid_i && trk_q.pending && (line_align(raddr_i) == trk_q.addr);

  // Next-state: allocate on command acceptance, fill beats in arrival order.
  always_comb begin
    trk_d        = trk_q;
    resp_valid_d = 1'b0;
    if (alloc_i) begin
      trk_d.pending  = 1'b1;
      trk_d.addr     = alloc_addr_i;
      trk_d.beat_cnt = '0;
    end
    if (hit) begin
      trk_d.line_buf[trk_q.beat_cnt*BEAT_W +: BEAT_W] = rdata_i;
      trk_d.beat_cnt = trk_q.beat_cnt + 2'd1;
      if (trk_q.beat_cnt == 2'(BEATS-1)) begin
        trk_d.pending = 1'b0;
        resp_valid_d  = 1'b1;
      end
    end
  end

  // Tracker and pulse registers; reset discards any partially gathered line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trk_q        <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      trk_q        <= trk_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign pending_o    = trk_q.pending;
  assign addr_o       = trk_q.addr;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = trk_q.line_buf;

endmodule

// File: rtl/bmem_arbiter.sv
// Arbitrates the single bmem port between the I-cache (reads) and the D-cache
// (reads and writebacks), issues line commands / write beats, and routes the
// returning read bursts to their owners through two line collectors.
module bmem_arbiter
  import bmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_read,
  output logic [LINE_W-1:0] i_resp_rdata,
  output logic              i_resp_valid,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic              d_req_read,
  input  logic              d_req_write,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic [LINE_W-1:0] d_resp_rdata,
  output logic              d_resp_valid,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  arb_state_t        state_q, state_d;
  req_id_t           owner_q, owner_d;
  req_id_t           last_grant_q, last_grant_d;
  req_id_t           win_sel;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              wr_done_q, wr_done_d;
  logic              bmem_read_q, bmem_read_d;
  logic              bmem_write_q, bmem_write_d;
  logic [ADDR_W-1:0] bmem_addr_q, bmem_addr_d;
  logic [BEAT_W-1:0] bmem_wdata_q, bmem_wdata_d;

  // Per-requester collector signals: index 0 is the I-cache, 1 is the D-cache.
  logic [1:0]        alloc;
  logic [1:0]        pend;
  logic [1:0]        resp_valid;
  logic [ADDR_W-1:0] trk_addr   [2];
  logic [LINE_W-1:0] resp_rdata [2];

  logic              i_elig;
  logic              d_elig;
  logic              d_wr_hazard;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_col
      bmem_line_collector u_col (
        .clk          (clk),
        .rst          (rst),
        .alloc_i      (alloc[gi]),
        .alloc_addr_i (addr_q),
        .rvalid_i     (bmem_rvalid),
        .raddr_i      (bmem_raddr),
        .rdata_i      (bmem_rdata),
        .pending_o    (pend[gi]),
        .addr_o       (trk_addr[gi]),
        .resp_valid_o (resp_valid[gi]),
        .resp_rdata_o (resp_rdata[gi])
      );
    end
  endgenerate

  // A writeback must never overtake an outstanding read of the same line.
  // The response-pulse terms stop a still-held request from being re-granted
  // in the cycle its completion is being signalled.
  always_comb begin
    d_wr_hazard = (pend[0] && (line_align(d_req_addr) == trk_addr[0])) ||
                  (pend[1] && (line_align(d_req_addr) == trk_addr[1]));
    i_elig      = i_req_read && !pend[0] && !i_resp_valid;
    d_elig      = !d_resp_valid &&
                  ((d_req_read && !pend[1]) || (d_req_write && !d_wr_hazard));
  end

  // State register: FSM, grant bookkeeping and all registered bmem outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= REQ_I;
      last_grant_q <= REQ_I;
      addr_q       <= '0;
      wr_cnt_q     <= '0;
      wr_done_q    <= 1'b0;
      bmem_read_q  <= 1'b0;
      bmem_write_q <= 1'b0;
      bmem_addr_q  <= '0;
      bmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_done_q    <= wr_done_d;
      bmem_read_q  <= bmem_read_d;
      bmem_write_q <= bmem_write_d;
      bmem_addr_q  <= bmem_addr_d;
      bmem_wdata_q <= bmem_wdata_d;
    end
  end

  // Next-state: round-robin grant in IDLE, hold each command until accepted.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wr_cnt_d     = wr_cnt_q;
    wr_done_d    = 1'b0;
    alloc        = 2'b00;
    win_sel      = REQ_I;
    case (state_q)
      IDLE: begin
        if (i_elig || d_elig) begin
          if (i_elig && d_elig) begin
            win_sel = (last_grant_q == REQ_I) ? REQ_D : REQ_I;
          end else begin
            win_sel = d_elig ? REQ_D : REQ_I;
          end
          owner_d      = win_sel;
          last_grant_d = win_sel;
          addr_d       = line_align((win_sel == REQ_D) ? d_req_addr : i_req_addr);
          if ((win_sel == REQ_D) && d_req_write) begin
            state_d  = WR_BEAT;
            wr_cnt_d = '0;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end
      RD_ISSUE: begin
        if (bmem_ready) begin
          state_d = IDLE;
          if (owner_q == REQ_D) begin
            alloc[1] = 1'b1;
          end else begin
            alloc[0] = 1'b1;
          end
        end
      end
      WR_BEAT: begin
        if (bmem_ready) begin
          if (wr_cnt_q == 2'(BEATS-1)) begin
            state_d   = IDLE;
            wr_done_d = 1'b1;
          end else begin
            wr_cnt_d = wr_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the next state so every bmem output leaves a flop.
  always_comb begin
    bmem_read_d  = (state_d == RD_ISSUE);
    bmem_write_d = (state_d == WR_BEAT);
    bmem_addr_d  = (state_d != IDLE) ? addr_d : '0;
    bmem_wdata_d = bmem_write_d ? d_req_wdata[wr_cnt_d*BEAT_W +: BEAT_W] : '0;
  end

  assign bmem_read    = bmem_read_q;
  assign bmem_write   = bmem_write_q;
  assign bmem_addr    = bmem_addr_q;
  assign bmem_wdata   = bmem_wdata_q;

  assign i_resp_valid = resp_valid[0];
  assign i_resp_rdata = resp_rdata[0];
  // Read completion and write completion are both flop outputs and cannot
  // coincide: the D-cache holds one request at a time.
  assign d_resp_valid = resp_valid[1] | wr_done_q;
  assign d_resp_rdata = resp_rdata[1];

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: a table of single-requester transactions
// plus hand-written sequences for arbitration, sharing, hazard and reset.
module tb_bmem_arbiter;
  import bmem_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_req_read;
  logic [LINE_W-1:0] i_resp_rdata;
  logic              i_resp_valid;
  logic [ADDR_W-1:0] d_req_addr;
  logic              d_req_read;
  logic              d_req_write;
  logic [LINE_W-1:0] d_req_wdata;
  logic [LINE_W-1:0] d_resp_rdata;
  logic              d_resp_valid;
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_read;
  logic              bmem_write;
  logic [BEAT_W-1:0] bmem_wdata;
  logic              bmem_ready;
  logic [ADDR_W-1:0] bmem_raddr;
  logic [BEAT_W-1:0] bmem_rdata;
  logic              bmem_rvalid;

  bmem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_addr   (i_req_addr),
    .i_req_read   (i_req_read),
    .i_resp_rdata (i_resp_rdata),
    .i_resp_valid (i_resp_valid),
    .d_req_addr   (d_req_addr),
    .d_req_read   (d_req_read),
    .d_req_write  (d_req_write),
    .d_req_wdata  (d_req_wdata),
    .d_resp_rdata (d_resp_rdata),
    .d_resp_valid (d_resp_valid),
    .bmem_addr    (bmem_addr),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_ready   (bmem_ready),
    .bmem_raddr   (bmem_raddr),
    .bmem_rdata   (bmem_rdata),
    .bmem_rvalid  (bmem_rvalid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    bit                is_d;
    bit                is_wr;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] exp_addr;
    logic [LINE_W-1:0] line;   // beat 0 in [63:0]
  } vec_t;

  vec_t vecs [4];

  // Line constants, written beat 3 first so beat 0 lands in bits [63:0].
  localparam logic [LINE_W-1:0] L_TIE_I = {64'h1111_0000_0000_0003, 64'h1111_0000_0000_0002,
                                           64'h1111_0000_0000_0001, 64'h1111_0000_0000_0000};
  localparam logic [LINE_W-1:0] L_TIE_D = {64'h2222_0000_0000_0003, 64'h2222_0000_0000_0002,
                                           64'h2222_0000_0000_0001, 64'h2222_0000_0000_0000};
  localparam logic [LINE_W-1:0] L_SAME  = {64'h5A5A_5A5A_0000_0003, 64'hA5A5_A5A5_0000_0002,
                                           64'h5A5A_5A5A_0000_0001, 64'hA5A5_A5A5_0000_0000};
  localparam logic [LINE_W-1:0] L_WTOG  = {64'hDEAD_BEEF_0000_0003, 64'hCAFE_F00D_0000_0002,
                                           64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210};
  localparam logic [LINE_W-1:0] L_HAZ_I = {64'h3333_0000_0000_0003, 64'h3333_0000_0000_0002,
                                           64'h3333_0000_0000_0001, 64'h3333_0000_0000_0000};
  localparam logic [LINE_W-1:0] L_HAZ_W = {64'h4444_0000_0000_0003, 64'h4444_0000_0000_0002,
                                           64'h4444_0000_0000_0001, 64'h4444_0000_0000_0000};
  localparam logic [LINE_W-1:0] L_RST   = {64'h7777_0000_0000_0003, 64'h7777_0000_0000_0002,
                                           64'h7777_0000_0000_0001, 64'h7777_0000_0000_0000};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_line(input logic [ADDR_W-1:0] tag, input logic [LINE_W-1:0] line);
    for (int b = 0; b < BEATS; b++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = tag;
      bmem_rdata  = line[b*BEAT_W +: BEAT_W];
      step();
    end
    bmem_rvalid = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_bmem_read"},  bmem_read,    0);
    chk({tag, "_bmem_write"}, bmem_write,   0);
    chk({tag, "_bmem_addr"},  bmem_addr,    0);
    chk({tag, "_bmem_wdata"}, bmem_wdata,   0);
    chk({tag, "_i_valid"},    i_resp_valid, 0);
    chk({tag, "_d_valid"},    d_resp_valid, 0);
    chk({tag, "_i_rdata"},    i_resp_rdata, 0);
    chk({tag, "_d_rdata"},    d_resp_rdata, 0);
  endtask

  // Hard stop in case a sequence stalls somewhere unexpected.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int k;
    bit ready_phase;
    bit got;

    vecs[0] = '{is_d: 1'b0, is_wr: 1'b0, addr: 32'h6000_0040, exp_addr: 32'h6000_0040,
                line: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                       64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}};
    vecs[1] = '{is_d: 1'b1, is_wr: 1'b0, addr: 32'h1234_567F, exp_addr: 32'h1234_5660,
                line: {64'h0D0D_0D0D_0D0D_0D0D, 64'h0C0C_0C0C_0C0C_0C0C,
                       64'h0B0B_0B0B_0B0B_0B0B, 64'h0A0A_0A0A_0A0A_0A0A}};
    vecs[2] = '{is_d: 1'b1, is_wr: 1'b1, addr: 32'h0000_00FF, exp_addr: 32'h0000_00E0,
                line: {64'h8888_0000_0000_0003, 64'h8888_0000_0000_0002,
                       64'h8888_0000_0000_0001, 64'h8888_0000_0000_0000}};
    vecs[3] = '{is_d: 1'b0, is_wr: 1'b0, addr: 32'hFFFF_FFFF, exp_addr: 32'hFFFF_FFE0,
                line: {64'hFFFF_0000_FFFF_0003, 64'hFFFF_0000_FFFF_0002,
                       64'hFFFF_0000_FFFF_0001, 64'hFFFF_0000_FFFF_0000}};

    rst         = 1'b0;
    i_req_addr  = '0;
    i_req_read  = 1'b0;
    d_req_addr  = '0;
    d_req_read  = 1'b0;
    d_req_write = 1'b0;
    d_req_wdata = '0;
    bmem_ready  = 1'b0;
    bmem_raddr  = '0;
    bmem_rdata  = '0;
    bmem_rvalid = 1'b0;

    // Reset state, with requests active to show they are ignored under reset.
    step();
    i_req_addr = 32'h6000_0040;
    i_req_read = 1'b1;
    d_req_addr = 32'h6000_0080;
    d_req_read = 1'b1;
    bmem_ready = 1'b1;
    step();
    step();
    check_all_zero("reset");
    i_req_read = 1'b0;
    d_req_read = 1'b0;
    rst = 1'b1;
    step();

    // First tie after reset goes to D, then I; returns arrive I-line first.
    i_req_addr = 32'h6000_1000;
    i_req_read = 1'b1;
    d_req_addr = 32'h6000_2004;
    d_req_read = 1'b1;
    bmem_ready = 1'b1;
    step();
    chk("tie_first_read", bmem_read, 1);
    chk("tie_first_addr", bmem_addr, 32'h6000_2000);
    step();
    chk("tie_gap_read", bmem_read, 0);
    step();
    chk("tie_second_read", bmem_read, 1);
    chk("tie_second_addr", bmem_addr, 32'h6000_1000);
    step();
    chk("tie_second_drop", bmem_read, 0);
    repeat (3) step();
    send_line(32'h6000_1000, L_TIE_I);
    chk("tie_i_valid", i_resp_valid, 1);
    chk("tie_i_rdata", i_resp_rdata, L_TIE_I);
    chk("tie_d_quiet", d_resp_valid, 0);
    i_req_read = 1'b0;
    step();
    chk("tie_i_pulse_end", i_resp_valid, 0);
    send_line(32'h6000_2000, L_TIE_D);
    chk("tie_d_valid", d_resp_valid, 1);
    chk("tie_d_rdata", d_resp_rdata, L_TIE_D);
    chk("tie_i_quiet", i_resp_valid, 0);
    d_req_read = 1'b0;
    step();

    // Table of single-requester transactions.
    for (int v = 0; v < 4; v++) begin
      bmem_ready = 1'b1;
      if (!vecs[v].is_d) begin
        i_req_addr = vecs[v].addr;
        i_req_read = 1'b1;
      end else if (vecs[v].is_wr) begin
        d_req_addr  = vecs[v].addr;
        d_req_wdata = vecs[v].line;
        d_req_write = 1'b1;
      end else begin
        d_req_addr = vecs[v].addr;
        d_req_read = 1'b1;
      end
      step();
      chk($sformatf("vec%0d_cmd", v), vecs[v].is_wr ? bmem_write : bmem_read, 1);
      chk($sformatf("vec%0d_addr", v), bmem_addr, vecs[v].exp_addr);
      if (vecs[v].is_wr) begin
        for (int b = 0; b < BEATS; b++) begin
          chk($sformatf("vec%0d_wbeat%0d", v, b), bmem_wdata, vecs[v].line[b*BEAT_W +: BEAT_W]);
          step();
        end
        chk($sformatf("vec%0d_wdone", v), d_resp_valid, 1);
        chk($sformatf("vec%0d_wr_off", v), bmem_write, 0);
        d_req_write = 1'b0;
        step();
        chk($sformatf("vec%0d_wdone_end", v), d_resp_valid, 0);
      end else begin
        step();
        chk($sformatf("vec%0d_read_1cyc", v), bmem_read, 0);
        repeat (10) step();
        send_line(vecs[v].exp_addr, vecs[v].line);
        if (vecs[v].is_d) begin
          chk($sformatf("vec%0d_valid", v), d_resp_valid, 1);
          chk($sformatf("vec%0d_rdata", v), d_resp_rdata, vecs[v].line);
          chk($sformatf("vec%0d_other", v), i_resp_valid, 0);
          d_req_read = 1'b0;
          step();
          chk($sformatf("vec%0d_valid_end", v), d_resp_valid, 0);
        end else begin
          chk($sformatf("vec%0d_valid", v), i_resp_valid, 1);
          chk($sformatf("vec%0d_rdata", v), i_resp_rdata, vecs[v].line);
          chk($sformatf("vec%0d_other", v), d_resp_valid, 0);
          i_req_read = 1'b0;
          step();
          chk($sformatf("vec%0d_valid_end", v), i_resp_valid, 0);
        end
      end
    end

    // I and D read the same line: one burst completes both.
    i_req_addr = 32'h6000_0080;
    d_req_addr = 32'h6000_0088;
    i_req_read = 1'b1;
    d_req_read = 1'b1;
    bmem_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bmem_read) n++;
    end
    chk("same_cmd_count", n, 2);
    send_line(32'h6000_0080, L_SAME);
    chk("same_i_valid", i_resp_valid, 1);
    chk("same_d_valid", d_resp_valid, 1);
    chk("same_i_rdata", i_resp_rdata, L_SAME);
    chk("same_d_rdata", d_resp_rdata, L_SAME);
    i_req_read = 1'b0;
    d_req_read = 1'b0;
    step();

    // Write with bmem_ready toggling 1,0,1,0 while the command is up.
    d_req_addr  = 32'h6000_0100;
    d_req_wdata = L_WTOG;
    d_req_write = 1'b1;
    bmem_ready  = 1'b0;
    ready_phase = 1'b1;
    k = 0;
    n = 0;
    for (int c = 0; c < 30 && k < BEATS; c++) begin
      step();
      if (d_resp_valid) n++;
      if (bmem_write) begin
        bmem_ready = ready_phase;
        if (ready_phase) begin
          chk($sformatf("wtog_beat%0d", k), bmem_wdata, L_WTOG[k*BEAT_W +: BEAT_W]);
          chk($sformatf("wtog_addr%0d", k), bmem_addr, 32'h6000_0100);
          k++;
        end
        ready_phase = !ready_phase;
      end else begin
        bmem_ready = 1'b0;
      end
    end
    chk("wtog_beats_accepted", k, BEATS);
    chk("wtog_no_early_done", n, 0);
    step();
    chk("wtog_done", d_resp_valid, 1);
    chk("wtog_write_off", bmem_write, 0);
    d_req_write = 1'b0;
    bmem_ready  = 1'b1;
    step();

    // Writeback to a line with an I read in flight waits for that read.
    i_req_addr = 32'h6000_0200;
    i_req_read = 1'b1;
    step();
    step();
    d_req_addr  = 32'h6000_0200;
    d_req_wdata = L_HAZ_W;
    d_req_write = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bmem_write) n++;
    end
    chk("haz_no_write", n, 0);
    send_line(32'h6000_0200, L_HAZ_I);
    chk("haz_i_valid", i_resp_valid, 1);
    chk("haz_i_rdata", i_resp_rdata, L_HAZ_I);
    chk("haz_write_held", bmem_write, 0);
    i_req_read = 1'b0;
    step();
    chk("haz_write_after", bmem_write, 1);
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      step();
      if (d_resp_valid) got = 1'b1;
    end
    chk("haz_write_done", got, 1);
    d_req_write = 1'b0;
    step();

    // Reset after a read is accepted; its burst must be dropped.
    i_req_addr = 32'h6000_0300;
    i_req_read = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    i_req_read = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    n = 0;
    for (int b = 0; b < BEATS; b++) begin
      bmem_rvalid = 1'b1;
      bmem_raddr  = 32'h6000_0300;
      bmem_rdata  = L_RST[b*BEAT_W +: BEAT_W];
      step();
      if (i_resp_valid || d_resp_valid) n++;
    end
    bmem_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (i_resp_valid || d_resp_valid || bmem_read) n++;
    end
    chk("midrst_dropped", n, 0);
    chk("midrst_i_rdata", i_resp_rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
